// File: rtl/uart_frame_ctrl.sv
// UART frame parser: syncs on SYNC0/SYNC1, packs N*16 payload bytes MSB-first into 128-bit
// FIFO writes (wr_en 1 cycle after the 16th byte), checks the XOR checksum, flushes on idle timeout.
module uart_frame_ctrl #(
  parameter logic [7:0]  SYNC0       = 8'h55,
  parameter logic [7:0]  SYNC1       = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter logic [7:0]  PAD_BYTE    = 8'h00
) (
  input  logic         wdata_fifo_wr_clk,
  input  logic         Rst_n,
  input  logic         rx_done,
  input  logic [7:0]   rx_data,
  input  logic         fifo_full,
  output logic         wr_en,
  output logic [127:0] wr_data,
  output logic         frame_start,
  output logic         frame_done,
  output logic         frame_err,
  output logic [15:0]  frame_cnt,
  output logic         busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LEN_H,
    S_LEN_L,
    S_PAYLOAD,
    S_CSUM,
    S_FLUSH
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t         state_q;
  logic [7:0]     len_h_q;
  logic [15:0]    len_q;
  logic [3:0]     byte_cnt_q;
  logic [15:0]    word_cnt_q;
  logic [7:0]     csum_q;
  logic           ovf_q;
  logic [127:0]   shreg_q;
  logic [15:0]    to_cnt_q;
  logic           wr_en_q;
  logic [127:0]   wr_data_q;
  logic           frame_start_q;
  logic           frame_done_q;
  logic           frame_err_q;
  logic [15:0]    frame_cnt_q;

  logic [127:0]   shreg_d;
  logic [7:0]     csum_d;
  logic [15:0]    to_cnt_d;
  logic           timeout_hit;
  logic [127:0]   flush_word;

  always_comb begin
    shreg_d     = {shreg_q[119:0], rx_data};
    csum_d      = csum_q ^ rx_data;
    to_cnt_d    = (state_q == S_IDLE || rx_done) ? 16'd0 : to_cnt_q + 16'd1;
    // The cycle in which the counter would reach TIMEOUT_CYC; a concurrent byte cancels it.
    timeout_hit = (state_q != S_IDLE) && !rx_done && (to_cnt_q == TO_LAST);
  end

  // Received bytes sit in the low byte_cnt lanes of shreg_q; move them to the top and pad below.
  always_comb begin
    flush_word = shreg_q << {5'd16 - {1'b0, byte_cnt_q}, 3'b000};
    for (int j = 0; j < 16; j++) begin
      if (j < 16 - int'(byte_cnt_q)) begin
        flush_word[8*j +: 8] = PAD_BYTE;
      end
    end
  end

  always_ff @(posedge wdata_fifo_wr_clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q       <= S_IDLE;
      len_h_q       <= 8'd0;
      len_q         <= 16'd0;
      byte_cnt_q    <= 4'd0;
      word_cnt_q    <= 16'd0;
      csum_q        <= 8'd0;
      ovf_q         <= 1'b0;
      shreg_q       <= 128'd0;
      to_cnt_q      <= 16'd0;
      wr_en_q       <= 1'b0;
      wr_data_q     <= 128'd0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      wr_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      to_cnt_q      <= to_cnt_d;

      if (timeout_hit && state_q != S_FLUSH) begin
        if (state_q == S_PAYLOAD && byte_cnt_q != 4'd0) begin
          state_q <= S_FLUSH;
        end else begin
          frame_err_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (rx_done && rx_data == SYNC0) state_q <= S_SYNC;
          end
          S_SYNC: begin
            if (rx_done) begin
              if (rx_data == SYNC1)      state_q <= S_LEN_H;
              else if (rx_data != SYNC0) state_q <= S_IDLE;
            end
          end
          S_LEN_H: begin
            if (rx_done) begin
              len_h_q <= rx_data;
              state_q <= S_LEN_L;
            end
          end
          S_LEN_L: begin
            if (rx_done) begin
              len_q <= {len_h_q, rx_data};
              if ({len_h_q, rx_data} == 16'd0) begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
              end else begin
                frame_start_q <= 1'b1;
                byte_cnt_q    <= 4'd0;
                word_cnt_q    <= 16'd0;
                csum_q        <= 8'd0;
                ovf_q         <= 1'b0;
                state_q       <= S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (rx_done) begin
              shreg_q    <= shreg_d;
              csum_q     <= csum_d;
              byte_cnt_q <= byte_cnt_q + 4'd1;
              if (byte_cnt_q == 4'hF) begin
                word_cnt_q <= word_cnt_q + 16'd1;
                if (!fifo_full) begin
                  wr_en_q   <= 1'b1;
                  wr_data_q <= shreg_d;
                end else begin
                  ovf_q <= 1'b1;
                end
                if (word_cnt_q + 16'd1 == len_q) state_q <= S_CSUM;
              end
            end
          end
          S_CSUM: begin
            if (rx_done) begin
              state_q <= S_IDLE;
              if (rx_data == csum_q && !ovf_q) begin
                frame_done_q <= 1'b1;
                frame_cnt_q  <= frame_cnt_q + 16'd1;
              end else begin
                frame_err_q <= 1'b1;
              end
            end
          end
          S_FLUSH: begin
            if (!fifo_full) begin
              wr_en_q   <= 1'b1;
              wr_data_q <= flush_word;
            end
            frame_err_q <= 1'b1;
            state_q     <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_data     = wr_data_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = (state_q != S_IDLE);

endmodule
